// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: per-bank open-row tracking, tRCD/tRP/tRAS timing, BL2/4/8 read/write bursts.
// One request in flight; req_ready only in IDLE with a legal burst_len, burst starts 0 cycles (row hit) or after PRE/ACT.
module ddr_cmd_scheduler #(
    parameter int ROW_WIDTH = 14,
    parameter int COL_WIDTH = 10,
    parameter int TRCD      = 2,
    parameter int TRP       = 2,
    parameter int TRAS      = 6
) (
    input  logic                          clk2x,
    input  logic                          rst,
    input  logic [2:0]                    burst_len,
    input  logic                          burst_type,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [1:0]                    req_ba,
    input  logic [ROW_WIDTH-1:0]          req_row,
    input  logic [COL_WIDTH-1:0]          req_col,
    input  logic [15:0]                   wr_data,
    output logic                          wr_beat,
    output logic                          rd_valid,
    output logic [1:0]                    ba,
    output logic [3:0][ROW_WIDTH-1:0]     ra,
    output logic [COL_WIDTH-1:0]          ca,
    output logic [3:0]                    row_active,
    output logic                          read_active,
    output logic                          write_active,
    output logic                          burst_stop,
    output logic [15:0]                   data_in,
    output logic                          busy,
    output logic                          illegal_cfg
);
    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE, PRE, PRE_WAIT, ACT, RCD_WAIT, RD_BURST, WR_BURST, GAP
    } state_t;

    state_t                       state_q, state_d;
    logic                         we_q, we_d;
    logic [1:0]                   bank_q, bank_d;
    logic [ROW_WIDTH-1:0]         row_q, row_d;
    logic [COL_WIDTH-1:0]         col_q, col_d;
    logic [2:0]                   last_q, last_d;
    logic [2:0]                   beat_q, beat_d;
    logic [CW-1:0]                trp_q, trp_d;
    logic [CW-1:0]                trcd_q, trcd_d;
    logic [3:0][CW-1:0]           tras_q, tras_d;
    logic [3:0][ROW_WIDTH-1:0]    ra_q, ra_d;
    logic [3:0]                   row_active_q, row_active_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [2:0]                   req_last;
    logic                         accept;

    // burst_type only changes the array's column order; command timing is identical for both.
    logic unused_burst_type;
    assign unused_burst_type = burst_type;

    always_comb begin
        req_last    = 3'd1;
        illegal_cfg = 1'b0;
        case (burst_len)
            3'd1:    req_last = 3'd1;
            3'd2:    req_last = 3'd3;
            3'd3:    req_last = 3'd7;
            default: illegal_cfg = 1'b1;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk2x) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            bank_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            last_q       <= '0;
            beat_q       <= '0;
            trp_q        <= '0;
            trcd_q       <= '0;
            tras_q       <= '0;
            ra_q         <= '0;
            row_active_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            col_q        <= col_d;
            last_q       <= last_d;
            beat_q       <= beat_d;
            trp_q        <= trp_d;
            trcd_q       <= trcd_d;
            tras_q       <= tras_d;
            ra_q         <= ra_d;
            row_active_q <= row_active_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        bank_d       = bank_q;
        row_d        = row_q;
        col_d        = col_q;
        last_d       = last_q;
        beat_d       = beat_q;
        trp_d        = trp_q;
        trcd_d       = trcd_q;
        ra_d         = ra_q;
        row_active_d = row_active_q;
        rd_valid_d   = (state_q == RD_BURST);
        for (int b = 0; b < 4; b++) begin
            tras_d[b] = (tras_q[b] == '0) ? '0 : tras_q[b] - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    bank_d = req_ba;
                    row_d  = req_row;
                    col_d  = req_col;
                    last_d = req_last;
                    beat_d = '0;
                    if (!row_active_q[req_ba]) begin
                        state_d = ACT;
                    end else if (ra_q[req_ba] == req_row) begin
                        state_d = req_we ? WR_BURST : RD_BURST;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                if (tras_q[bank_q] == '0) begin
                    row_active_d[bank_q] = 1'b0;
                    trp_d                = CW'(TRP - 1);
                    state_d              = PRE_WAIT;
                end
            end
            PRE_WAIT: begin
                if (trp_q == '0) state_d = ACT;
                else             trp_d   = trp_q - CNT_ONE;
            end
            ACT: begin
                ra_d[bank_q]         = row_q;
                row_active_d[bank_q] = 1'b1;
                tras_d[bank_q]       = CW'(TRAS - 1);
                trcd_d               = CW'(TRCD - 1);
                state_d              = RCD_WAIT;
            end
            RCD_WAIT: begin
                if (trcd_q == '0) state_d = we_q ? WR_BURST : RD_BURST;
                else              trcd_d  = trcd_q - CNT_ONE;
            end
            RD_BURST, WR_BURST: begin
                if (beat_q == last_q) begin
                    beat_d  = '0;
                    state_d = GAP;
                end else begin
                    beat_d  = beat_q + 3'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        req_ready    = (state_q == IDLE) && !illegal_cfg;
        read_active  = (state_q == RD_BURST);
        write_active = (state_q == WR_BURST);
        wr_beat      = write_active;
        data_in      = write_active ? wr_data : 16'h0000;
    end

    assign ba         = bank_q;
    assign ca         = col_q;
    assign ra         = ra_q;
    assign row_active = row_active_q;
    assign rd_valid   = rd_valid_q;
    assign burst_stop = 1'b0;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler with a small behavioural DDR array that follows the command strobes.
// TRAS is raised so the row-miss precharge really has to wait for tRAS.
module tb_ddr_cmd_scheduler;
    localparam int RW   = 14;
    localparam int CWD  = 10;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int TRAS = 30;
    localparam int NS   = 48;

    logic                 clk2x = 1'b0;
    logic                 rst = 1'b1;
    logic [2:0]           burst_len = 3'd2;
    logic                 burst_type = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_we = 1'b0;
    logic [1:0]           req_ba = '0;
    logic [RW-1:0]        req_row = '0;
    logic [CWD-1:0]       req_col = '0;
    logic [15:0]          wr_data = '0;
    logic                 wr_beat, rd_valid, read_active, write_active, burst_stop, busy, illegal_cfg;
    logic [1:0]           ba;
    logic [3:0][RW-1:0]   ra;
    logic [CWD-1:0]       ca;
    logic [3:0]           row_active;
    logic [15:0]          data_in;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int arr_bl = 4;

    ddr_cmd_scheduler #(
        .ROW_WIDTH(RW), .COL_WIDTH(CWD), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS)
    ) dut (
        .clk2x(clk2x), .rst(rst), .burst_len(burst_len), .burst_type(burst_type),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .wr_data(wr_data), .wr_beat(wr_beat),
        .rd_valid(rd_valid), .ba(ba), .ra(ra), .ca(ca), .row_active(row_active),
        .read_active(read_active), .write_active(write_active), .burst_stop(burst_stop),
        .data_in(data_in), .busy(busy), .illegal_cfg(illegal_cfg)
    );

    always #5 clk2x = ~clk2x;
    always @(posedge clk2x) cyc <= cyc + 1;

    // Behavioural array: beat index runs while a strobe is high and clears on the idle cycle.
    logic [15:0] mem [0:65535];
    logic [2:0]  idx = '0;
    logic [15:0] rd_dat = '0;

    function automatic logic [15:0] key(input logic [1:0] b, input logic [RW-1:0] r, input logic [CWD-1:0] c);
        return {b, r[3:0], c};
    endfunction

    function automatic logic [CWD-1:0] beat_col(input logic [CWD-1:0] c, input logic [2:0] i,
                                                input logic il, input int bl);
        logic [CWD-1:0] m;
        m = CWD'(bl - 1);
        if (il) return c ^ CWD'(i);
        return (c & ~m) | ((c + CWD'(i)) & m);
    endfunction

    always @(posedge clk2x) begin
        if (read_active || write_active) idx <= idx + 3'd1;
        else                             idx <= '0;
        if (write_active) mem[key(ba, ra[ba], beat_col(ca, idx, burst_type, arr_bl))] <= data_in;
        if (read_active)  rd_dat <= mem[key(ba, ra[ba], beat_col(ca, idx, burst_type, arr_bl))];
    end

    logic           s_wa [NS], s_ra [NS], s_rv [NS], s_wb [NS], s_busy [NS], s_row1 [NS];
    logic [15:0]    s_rd [NS], s_din [NS];
    logic [1:0]     s_ba [NS];
    logic [CWD-1:0] s_ca [NS];
    int             s_cyc [NS];
    logic [15:0]    wq [8];

    // Starts and ends on a falling edge; feeds wq on write beats and records one sample per cycle.
    task automatic run(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_beat && k < 8) begin
                wr_data = wq[k];
                k++;
            end else begin
                wr_data = 16'hDEAD;
            end
            #1;
            s_wa[i] = write_active; s_ra[i] = read_active; s_rv[i] = rd_valid;
            s_wb[i] = wr_beat;      s_busy[i] = busy;      s_row1[i] = row_active[1];
            s_rd[i] = rd_dat;       s_din[i] = data_in;    s_ba[i] = ba;
            s_ca[i] = ca;           s_cyc[i] = cyc;
            @(negedge clk2x);
        end
    endtask

    // Returns on the falling edge right after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] b, input logic [RW-1:0] r,
                         input logic [CWD-1:0] c, output logic ok);
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_ba = b; req_row = r; req_col = c;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            @(negedge clk2x);
            if (ok) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_data = 16'hFFFF;
        repeat (3) @(negedge clk2x);
        rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++; if (row_active !== 4'h0 || ra !== '0) begin miscompares++; $display("FAIL reset_rows: got %h/%h want 0/0", row_active, ra); end
        vectors++; if ({read_active, write_active, rd_valid, wr_beat, burst_stop} !== 5'b0) begin
            miscompares++; $display("FAIL reset_strobes: got %b want 00000", {read_active, write_active, rd_valid, wr_beat, burst_stop}); end
        vectors++; if (data_in !== 16'h0) begin miscompares++; $display("FAIL reset_data_in: got %h want 0", data_in); end
        vectors++; if (ca !== '0 || ba !== 2'b0) begin miscompares++; $display("FAIL reset_addr: got ba %0d ca %0d want 0 0", ba, ca); end
        vectors++; if (illegal_cfg !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal_cfg); end
        @(negedge clk2x);
    endtask

    task automatic test_write_closed();
        logic ok;
        int fw, nw, bad;
        burst_len = 3'd2; burst_type = 1'b0; arr_bl = 4;
        for (int i = 0; i < 4; i++) wq[i] = 16'h00A0 + 16'(i);
        issue(1'b1, 2'd1, 14'd5, 10'd8, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wr_accept: got timeout want accept"); end
        run(10);
        fw = -1; nw = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (s_wa[i]) begin
                nw++;
                if (fw < 0) fw = i;
                if (s_ca[i] != 10'd8 || s_ba[i] != 2'd1) bad++;
            end
            if (s_wb[i] != s_wa[i] || s_ra[i] || (!s_wa[i] && s_din[i] != 16'h0)) bad++;
        end
        vectors++; if (s_row1[0] !== 1'b0 || s_row1[1] !== 1'b1) begin
            miscompares++; $display("FAIL wr_act_rise: got %b%b want 01", s_row1[0], s_row1[1]); end
        vectors++; if (fw != 1 + TRCD) begin miscompares++; $display("FAIL wr_first_beat: got %0d want %0d", fw, 1 + TRCD); end
        vectors++; if (nw != 4) begin miscompares++; $display("FAIL wr_beats: got %0d want 4", nw); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wr_strobes: got %0d bad cycles want 0", bad); end
        vectors++; if (s_wa[7] !== 1'b0 || s_busy[7] !== 1'b1 || s_busy[8] !== 1'b0) begin
            miscompares++; $display("FAIL wr_gap: got wa %b busy %b%b want 0 10", s_wa[7], s_busy[7], s_busy[8]); end
        vectors++; if (ra[1] !== 14'd5) begin miscompares++; $display("FAIL wr_ra1: got %0d want 5", ra[1]); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[key(2'd1, 14'd5, 10'(8 + i))] !== 16'h00A0 + 16'(i)) begin
                miscompares++; $display("FAIL wr_array col %0d: got %h want %h", 8 + i, mem[key(2'd1, 14'd5, 10'(8 + i))], 16'h00A0 + 16'(i)); end
        end
        rise_cyc = s_cyc[1];
    endtask

    task automatic test_row_hit();
        logic ok;
        int nr, nv, closed;
        logic [15:0] exp_rd [4];
        exp_rd = '{16'h00A2, 16'h00A3, 16'h00A0, 16'h00A1};
        issue(1'b0, 2'd1, 14'd5, 10'd10, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hit_accept: got timeout want accept"); end
        run(8);
        nr = 0; nv = 0; closed = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_ra[i]) nr++;
            if (s_rv[i]) nv++;
            if (!s_row1[i]) closed++;
        end
        vectors++; if (closed != 0 || s_ra[0] !== 1'b1) begin
            miscompares++; $display("FAIL hit_no_pre_act: got closed %0d first_rd %b want 0 1", closed, s_ra[0]); end
        vectors++; if (nr != 4 || nv != 4 || s_rv[0] !== 1'b0) begin
            miscompares++; $display("FAIL hit_counts: got rd %0d valid %0d want 4 4", nr, nv); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (s_rd[i + 1] !== exp_rd[i]) begin miscompares++; $display("FAIL hit_data beat %0d: got %h want %h", i, s_rd[i + 1], exp_rd[i]); end
        end
    endtask

    task automatic test_row_miss();
        logic ok;
        int ff, rr, fr, zeros, nr, nv, held;
        issue(1'b0, 2'd1, 14'd6, 10'd0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL miss_accept: got timeout want accept"); end
        run(45);
        ff = -1; rr = -1; fr = -1; zeros = 0; nr = 0; nv = 0;
        for (int i = 0; i < 45; i++) begin
            if (!s_row1[i]) begin
                zeros++;
                if (ff < 0) ff = i;
            end else if (ff >= 0 && rr < 0) begin
                rr = i;
            end
            if (s_ra[i]) begin
                nr++;
                if (fr < 0) fr = i;
            end
            if (s_rv[i]) nv++;
        end
        held = (ff >= 0) ? s_cyc[ff] - rise_cyc : -1;
        vectors++; if (held != TRAS) begin miscompares++; $display("FAIL miss_tras: got open %0d cycles want %0d", held, TRAS); end
        // PRE_WAIT lasts TRP cycles and the ACT cycle itself is still closed.
        vectors++; if (zeros != TRP + 1) begin miscompares++; $display("FAIL miss_trp: got closed %0d want %0d", zeros, TRP + 1); end
        vectors++; if (fr - rr != TRCD || rr < 0) begin miscompares++; $display("FAIL miss_trcd: got %0d want %0d", fr - rr, TRCD); end
        vectors++; if (nr != 4 || nv != 4) begin miscompares++; $display("FAIL miss_counts: got rd %0d valid %0d want 4 4", nr, nv); end
        vectors++; if (ra[1] !== 14'd6) begin miscompares++; $display("FAIL miss_ra1: got %0d want 6", ra[1]); end
    endtask

    task automatic test_bl8_interleaved();
        logic ok;
        int nw, nr, nv, bad;
        logic [15:0] exp_col [8];
        exp_col = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd7, 16'd6, 16'd5, 16'd4};
        burst_len = 3'd3; burst_type = 1'b0; arr_bl = 8;
        for (int i = 0; i < 8; i++) wq[i] = 16'h00B0 + 16'(i);
        issue(1'b1, 2'd1, 14'd6, 10'd0, ok);
        run(10);
        nw = 0;
        for (int i = 0; i < 10; i++) if (s_wa[i]) nw++;
        vectors++; if (!ok || nw != 8) begin miscompares++; $display("FAIL bl8_write: got %0d beats want 8", nw); end
        burst_type = 1'b1;
        issue(1'b0, 2'd1, 14'd6, 10'd3, ok);
        burst_len = 3'd1;
        run(11);
        nr = 0; nv = 0; bad = 0;
        for (int i = 0; i < 11; i++) begin
            if (s_ra[i]) begin
                nr++;
                if (s_ca[i] != 10'd3) bad++;
            end
            if (s_rv[i]) nv++;
        end
        vectors++; if (!ok || nr != 8 || nv != 8 || bad != 0) begin
            miscompares++; $display("FAIL bl8_read: got rd %0d valid %0d badca %0d want 8 8 0", nr, nv, bad); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (s_rd[i + 1] !== 16'h00B0 + exp_col[i]) begin
                miscompares++; $display("FAIL bl8_data beat %0d: got %h want %h", i, s_rd[i + 1], 16'h00B0 + exp_col[i]); end
        end
        burst_len = 3'd2; burst_type = 1'b0;
    endtask

    task automatic test_illegal();
        logic [2:0] bad_codes [5];
        int cmd;
        bad_codes = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        req_we = 1'b1; req_ba = 2'd3; req_row = 14'd1; req_col = 10'd0;
        burst_len = 3'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            burst_len = bad_codes[i];
            #1;
            vectors++; if (illegal_cfg !== 1'b1 || req_ready !== 1'b0) begin
                miscompares++; $display("FAIL illegal code %0d: got cfg %b ready %b want 1 0", bad_codes[i], illegal_cfg, req_ready); end
            @(negedge clk2x);
        end
        burst_len = 3'd0;
        cmd = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (busy || read_active || write_active || wr_beat) cmd++;
            @(negedge clk2x);
        end
        vectors++; if (cmd != 0) begin miscompares++; $display("FAIL illegal_no_cmd: got %0d active cycles want 0", cmd); end
        req_valid = 1'b0;
        burst_len = 3'd2;
        #1;
        vectors++; if (illegal_cfg !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL illegal_recover: got cfg %b ready %b want 0 1", illegal_cfg, req_ready); end
        @(negedge clk2x);
    endtask

    task automatic test_reset_mid_burst();
        logic ok, hit;
        int beats, fw, nw;
        burst_len = 3'd3; burst_type = 1'b0; arr_bl = 8;
        issue(1'b1, 2'd2, 14'd7, 10'd0, ok);
        beats = 0; hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr_beat) begin
                wr_data = 16'h00E0 + 16'(beats);
                if (beats == 2) begin
                    rst = 1'b1;
                    hit = 1'b1;
                end
                beats++;
            end
            @(negedge clk2x);
            if (hit) break;
        end
        rst = 1'b0;
        wr_data = 16'h5555;
        #1;
        vectors++; if (!ok || !hit) begin miscompares++; $display("FAIL rstmid_reach_beat2: got timeout want beat 2"); end
        vectors++; if ({busy, read_active, write_active, wr_beat, rd_valid, burst_stop} !== 6'b0) begin
            miscompares++; $display("FAIL rstmid_strobes: got %b want 000000", {busy, read_active, write_active, wr_beat, rd_valid, burst_stop}); end
        vectors++; if (row_active !== 4'h0 || ra !== '0 || ca !== '0 || ba !== 2'd0) begin
            miscompares++; $display("FAIL rstmid_state: got rows %h ba %0d ca %0d want 0 0 0", row_active, ba, ca); end
        vectors++; if (data_in !== 16'h0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_idle: got din %h ready %b want 0 1", data_in, req_ready); end
        @(negedge clk2x);
        burst_len = 3'd2; arr_bl = 4;
        for (int i = 0; i < 4; i++) wq[i] = 16'h00C0 + 16'(i);
        issue(1'b1, 2'd0, 14'd3, 10'd4, ok);
        run(10);
        fw = -1; nw = 0;
        for (int i = 0; i < 10; i++) if (s_wa[i]) begin
            nw++;
            if (fw < 0) fw = i;
        end
        vectors++; if (!ok || fw != 1 + TRCD || nw != 4) begin
            miscompares++; $display("FAIL rstmid_next_write: got first %0d beats %0d want %0d 4", fw, nw, 1 + TRCD); end
        issue(1'b0, 2'd0, 14'd3, 10'd4, ok);
        run(8);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (!ok || s_rd[i + 1] !== 16'h00C0 + 16'(i)) begin
                miscompares++; $display("FAIL rstmid_read beat %0d: got %h want %h", i, s_rd[i + 1], 16'h00C0 + 16'(i)); end
        end
    endtask

    initial begin
        @(negedge clk2x);
        test_reset();
        test_write_closed();
        test_row_hit();
        test_row_miss();
        test_bl8_interleaved();
        test_illegal();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

endmodule
